// File: rtl/w_pattern_serializer_if.sv
// Bus between the pattern serializer and whatever drives and consumes it.
// The master loads patterns and controls the run; the slave shifts bits out on w.
interface w_pattern_serializer_if #(
    parameter int WIDTH = 16,
    parameter int LEN_W = $clog2(WIDTH + 1)
);
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic             loop;
    logic             stop;
    logic             w;
    logic             bit_stb;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, len, loop, stop,
        input  w, bit_stb, busy, done
    );

    modport slave (
        input  start, pattern, len, loop, stop,
        output w, bit_stb, busy, done
    );
endinterface

// File: rtl/w_pattern_serializer.sv
// Loads a parallel pattern and shifts it out on w, holding each bit DIV cycles,
// with one-shot, continuous-loop and abort operation. All outputs are registered.
module w_pattern_serializer #(
    parameter int WIDTH     = 16,
    parameter int DIV       = 4,
    parameter int MSB_FIRST = 1,
    parameter int LEN_W     = $clog2(WIDTH + 1)
) (
    input logic                    clk,
    input logic                    rst,
    w_pattern_serializer_if.slave  bus
);
    localparam int              DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] bit_q, bit_d;
    logic [DW-1:0]    div_q, div_d;
    logic             w_q, w_d;
    logic             stb_q, stb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] len_clamp;

    // Returns the k-th bit to transmit out of an n-bit pattern, honouring bit order.
    function automatic logic bit_at(input logic [WIDTH-1:0] p,
                                    input logic [LEN_W-1:0] n,
                                    input logic [LEN_W-1:0] k);
        logic [LEN_W-1:0] idx;
        logic             r;
        if (MSB_FIRST != 0)
            idx = n - LEN_W'(1) - k;
        else
            idx = k;
        r = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (idx == LEN_W'(i))
                r = p[i];
        end
        return r;
    endfunction

    always_comb begin
        len_clamp = (bus.len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : bus.len;
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        bit_d   = bit_q;
        div_d   = div_q;
        w_d     = w_q;
        stb_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start && (bus.len != '0)) begin
                    pat_d   = bus.pattern;
                    len_d   = len_clamp;
                    bit_d   = '0;
                    div_d   = '0;
                    w_d     = bit_at(bus.pattern, len_clamp, '0);
                    stb_d   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                // Abort wins over everything else, including the end of a pass.
                if (bus.stop) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    w_d     = 1'b0;
                    bit_d   = '0;
                    div_d   = '0;
                end else if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == (len_q - LEN_W'(1))) begin
                        bit_d = '0;
                        if (bus.loop) begin
                            w_d   = bit_at(pat_q, len_q, '0);
                            stb_d = 1'b1;
                        end else begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + LEN_W'(1);
                        w_d   = bit_at(pat_q, len_q, bit_q + LEN_W'(1));
                        stb_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            w_q     <= 1'b0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            w_q     <= w_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.w       = w_q;
    assign bus.bit_stb = stb_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_w_pattern_serializer.sv
// Bench for w_pattern_serializer: two instances (DIV=4 MSB-first, DIV=1 LSB-first)
// checked every cycle against a per-bit behavioural model, plus literal sequences.
module tb_w_pattern_serializer;
    logic clk;
    logic rst;

    w_pattern_serializer_if #(.WIDTH(16)) bus_a ();
    w_pattern_serializer_if #(.WIDTH(8))  bus_b ();

    w_pattern_serializer #(.WIDTH(16), .DIV(4), .MSB_FIRST(1)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    w_pattern_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(0)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    // Model state, index 0 = instance a, 1 = instance b.
    int          divs [2] = '{4, 1};
    int          msbf [2] = '{1, 0};
    int          wid  [2] = '{16, 8};
    logic        m_busy [2];
    logic        m_done [2];
    logic        m_w    [2];
    logic        m_stb  [2];
    logic [15:0] m_bits [2];
    int          m_n    [2];
    int          m_pos  [2];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the model: pos counts cycles into the current pass.
    task automatic model_step(input int i, input logic s, input logic [15:0] pat,
                              input int ln, input logic lp, input logic sp);
        if (m_done[i]) begin
            m_done[i] = 1'b0;
            m_stb[i]  = 1'b0;
        end else if (m_busy[i]) begin
            if (sp) begin
                m_busy[i] = 1'b0;
                m_w[i]    = 1'b0;
                m_stb[i]  = 1'b0;
            end else begin
                m_pos[i]++;
                if (m_pos[i] == m_n[i] * divs[i]) begin
                    if (lp) begin
                        m_pos[i] = 0;
                    end else begin
                        m_busy[i] = 1'b0;
                        m_done[i] = 1'b1;
                        m_stb[i]  = 1'b0;
                    end
                end
                if (m_busy[i]) begin
                    m_w[i]   = m_bits[i][m_pos[i] / divs[i]];
                    m_stb[i] = ((m_pos[i] % divs[i]) == 0);
                end
            end
        end else begin
            m_stb[i] = 1'b0;
            if (s && ln != 0) begin
                m_n[i] = (ln > wid[i]) ? wid[i] : ln;
                for (int k = 0; k < m_n[i]; k++)
                    m_bits[i][k] = (msbf[i] != 0) ? pat[m_n[i] - 1 - k] : pat[k];
                m_pos[i]  = 0;
                m_busy[i] = 1'b1;
                m_w[i]    = m_bits[i][0];
                m_stb[i]  = 1'b1;
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 1'b0;
                m_done[i] = 1'b0;
                m_w[i]    = 1'b0;
                m_stb[i]  = 1'b0;
                m_pos[i]  = 0;
                m_n[i]    = 0;
            end
        end else begin
            model_step(0, bus_a.start, bus_a.pattern, int'(bus_a.len), bus_a.loop, bus_a.stop);
            model_step(1, bus_b.start, {8'h00, bus_b.pattern}, int'(bus_b.len), bus_b.loop, bus_b.stop);
        end
    end

    always @(negedge clk) begin
        checkOutput("a.w",       bus_a.w,       m_w[0]);
        checkOutput("a.bit_stb", bus_a.bit_stb, m_stb[0]);
        checkOutput("a.busy",    bus_a.busy,    m_busy[0]);
        checkOutput("a.done",    bus_a.done,    m_done[0]);
        checkOutput("b.w",       bus_b.w,       m_w[1]);
        checkOutput("b.bit_stb", bus_b.bit_stb, m_stb[1]);
        checkOutput("b.busy",    bus_b.busy,    m_busy[1]);
        checkOutput("b.done",    bus_b.done,    m_done[1]);
    end

    task automatic applyStimulus(input int inst, input logic s, input logic [15:0] pat,
                                 input logic [4:0] ln, input logic lp, input logic sp);
        @(posedge clk);
        #1;
        if (inst == 0) begin
            bus_a.start   = s;
            bus_a.pattern = pat;
            bus_a.len     = ln;
            bus_a.loop    = lp;
            bus_a.stop    = sp;
        end else begin
            bus_b.start   = s;
            bus_b.pattern = pat[7:0];
            bus_b.len     = (ln > 5'd15) ? 4'd15 : ln[3:0];
            bus_b.loop    = lp;
            bus_b.stop    = sp;
        end
    endtask

    initial begin
        logic [12:0] wv, sv, bv, dv;
        int          cnt;
        logic        seen;

        rst = 1'b1;
        bus_a.start = 0; bus_a.pattern = '0; bus_a.len = '0; bus_a.loop = 0; bus_a.stop = 0;
        bus_b.start = 0; bus_b.pattern = '0; bus_b.len = '0; bus_b.loop = 0; bus_b.stop = 0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        @(negedge clk);
        checkOutput("reset_busy_w_stb_done", {bus_a.busy, bus_a.w, bus_a.bit_stb, bus_a.done}, 4'b0000);

        // DIV=4, len=3, pattern 101
        applyStimulus(0, 1'b1, 16'b101, 5'd3, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0);
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            wv[k] = bus_a.w; sv[k] = bus_a.bit_stb; bv[k] = bus_a.busy; dv[k] = bus_a.done;
        end
        checkOutput("div4_w_seq",    wv, 13'b1111100001111);
        checkOutput("div4_stb_seq",  sv, 13'b0000100010001);
        checkOutput("div4_busy_seq", bv, 13'b0111111111111);
        checkOutput("div4_done_seq", dv, 13'b1000000000000);

        // DIV=1, LSB-first, 8'hF0 sends 0,0,0,0,1,1,1,1
        applyStimulus(1, 1'b1, 16'h00F0, 5'd8, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0);
        wv = '0; sv = '0; bv = '0; dv = '0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            wv[k] = bus_b.w; sv[k] = bus_b.bit_stb; bv[k] = bus_b.busy; dv[k] = bus_b.done;
        end
        checkOutput("div1_w_seq",    wv, 13'b0000111110000);
        checkOutput("div1_stb_seq",  sv, 13'b0000011111111);
        checkOutput("div1_busy_seq", bv, 13'b0000011111111);
        checkOutput("div1_done_seq", dv, 13'b0000100000000);

        // len=0 is ignored entirely
        applyStimulus(0, 1'b1, 16'hFFFF, 5'd0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            seen = seen | bus_a.busy | bus_a.done;
        end
        checkOutput("len0_no_busy_done", seen, 1'b0);

        // len=20 clamps to 16 bits of 4 cycles each
        applyStimulus(0, 1'b1, 16'hA5C3, 5'd20, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0);
        cnt = 0;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (bus_a.busy) cnt++;
            if (bus_a.done) seen = 1'b1;
        end
        checkOutput("len20_busy_cycles", cnt, 64);
        checkOutput("len20_done_seen", seen, 1'b1);

        // Looping 2-bit pattern, LSB-first 01 -> 1,0,1,0...
        applyStimulus(1, 1'b1, 16'h0001, 5'd2, 1'b1, 1'b0);
        applyStimulus(1, 1'b0, 16'h0001, 5'd2, 1'b1, 1'b0);
        wv = '0; bv = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            wv[k] = bus_b.w; bv[k] = bus_b.busy;
        end
        checkOutput("loop_w_seq",    wv, 13'b0000000010101);
        checkOutput("loop_busy_seq", bv, 13'b0000000111111);
        applyStimulus(1, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (bus_b.done) seen = 1'b1;
        end
        checkOutput("loop_drop_done", seen, 1'b1);

        // Start while busy is ignored; stop during the third bit aborts cleanly
        applyStimulus(0, 1'b1, 16'h00B4, 5'd8, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 16'h00B4, 5'd8, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 16'hFFFF, 5'd4, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0);
        repeat (6) applyStimulus(0, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("stop_busy_w_stb", {bus_a.busy, bus_a.w, bus_a.bit_stb}, 3'b000);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            seen = seen | bus_a.done;
        end
        checkOutput("stop_no_done", seen, 1'b0);

        // Asynchronous reset in the middle of a pass
        applyStimulus(0, 1'b1, 16'h00FF, 5'd8, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_rst_outputs", {bus_a.busy, bus_a.w, bus_a.bit_stb, bus_a.done}, 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(0, 1'b1, 16'h0001, 5'd1, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("post_rst_first_bit", {bus_a.busy, bus_a.w, bus_a.bit_stb}, 3'b111);

        // Randomized traffic on both instances
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1;
            bus_a.start   = ($urandom_range(0, 5) == 0);
            bus_a.pattern = 16'($urandom);
            bus_a.len     = 5'($urandom_range(0, 20));
            bus_a.loop    = ($urandom_range(0, 2) == 0);
            bus_a.stop    = ($urandom_range(0, 39) == 0);
            bus_b.start   = ($urandom_range(0, 5) == 0);
            bus_b.pattern = 8'($urandom);
            bus_b.len     = 4'($urandom_range(0, 12));
            bus_b.loop    = ($urandom_range(0, 2) == 0);
            bus_b.stop    = ($urandom_range(0, 39) == 0);
        end
        applyStimulus(0, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
